// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer sequencer and its watchdog.
package layer_seq_pkg;

   typedef logic [1:0] state_bits_t;

   typedef enum state_bits_t {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT    = 2'd2,
      ADVANCE = 2'd3
   } state_t;

   // $clog2 that never returns less than 1, so a 1-entry range still gets a bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer wait timer: clearable, saturating counter that flags the last allowed WAIT cycle.
module layer_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_in;
         assign unused_in = ^{clk, reset, clear, enable};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);
         logic [TO_W-1:0] count;

         // Holds at LAST rather than wrapping; the sequencer leaves WAIT on expiry anyway.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               count <= '0;
            else if (clear)
               count <= '0;
            else if (enable && count != LAST)
               count <= count + 1'b1;
         end

         assign expired = (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Walks NUM_LAYERS layers, launching the RAM/MAC controller per layer and waiting for its done.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int NUM_LAYERS     = 4,
   parameter int LAYER_W        = clog2_min1(NUM_LAYERS),
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = clog2_min1(TIMEOUT_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               done,
   input  logic               abort,
   output logic [LAYER_W-1:0] layer,
   output logic               layer_sel,
   output logic               ram_start,
   output logic               busy,
   output logic               net_done,
   output logic               timeout_err
);

   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

   state_t state;
   logic   expired;
   logic   last_layer;

   assign last_layer = (layer == LAST_LAYER);
   assign layer_sel  = !last_layer;

   layer_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (abort || state == LAUNCH),
      .enable  (state == WAIT && !done),
      .expired (expired)
   );

   // Pulse outputs and busy are loaded alongside the next state so each is a clean flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         layer       <= '0;
         timeout_err <= 1'b0;
         ram_start   <= 1'b0;
         busy        <= 1'b0;
         net_done    <= 1'b0;
      end else begin
         ram_start <= 1'b0;
         net_done  <= 1'b0;
         if (abort) begin
            state <= IDLE;
            layer <= '0;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state       <= LAUNCH;
                     layer       <= '0;
                     timeout_err <= 1'b0;
                     ram_start   <= 1'b1;
                     busy        <= 1'b1;
                  end
               end
               LAUNCH: state <= WAIT;
               WAIT: begin
                  if (done) begin
                     state    <= ADVANCE;
                     net_done <= last_layer;
                  end else if (expired) begin
                     state       <= IDLE;
                     layer       <= '0;
                     timeout_err <= 1'b1;
                     busy        <= 1'b0;
                  end
               end
               ADVANCE: begin
                  if (last_layer) begin
                     state <= IDLE;
                     layer <= '0;
                     busy  <= 1'b0;
                  end else begin
                     state     <= LAUNCH;
                     layer     <= layer + 1'b1;
                     ram_start <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  layer <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Random-stimulus bench for three sequencer builds (4/8, 1/3, 5/off) against a cycle model.
module tb_layer_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic st [3];
   logic dn [3];
   logic ab [3];
   logic rs [3];
   logic ls [3];
   logic bz [3];
   logic nd [3];
   logic te [3];
   logic [1:0] l4;
   logic [0:0] l1;
   logic [2:0] l5;

   int n_tests = 0;
   int n_fail  = 0;

   // model state per build: phase 0 idle, 1 launch, 2 wait, 3 advance
   int m_phase [3];
   int m_lay   [3];
   int m_wait  [3];
   int m_terr  [3];

   always #5 clk = ~clk;

   layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT_CYCLES(8)) u4 (
      .clk(clk), .reset(reset), .start(st[0]), .done(dn[0]), .abort(ab[0]),
      .layer(l4), .layer_sel(ls[0]), .ram_start(rs[0]), .busy(bz[0]),
      .net_done(nd[0]), .timeout_err(te[0]));

   layer_sequencer #(.NUM_LAYERS(1), .TIMEOUT_CYCLES(3)) u1 (
      .clk(clk), .reset(reset), .start(st[1]), .done(dn[1]), .abort(ab[1]),
      .layer(l1), .layer_sel(ls[1]), .ram_start(rs[1]), .busy(bz[1]),
      .net_done(nd[1]), .timeout_err(te[1]));

   layer_sequencer #(.NUM_LAYERS(5), .TIMEOUT_CYCLES(0)) u5 (
      .clk(clk), .reset(reset), .start(st[2]), .done(dn[2]), .abort(ab[2]),
      .layer(l5), .layer_sel(ls[2]), .ram_start(rs[2]), .busy(bz[2]),
      .net_done(nd[2]), .timeout_err(te[2]));

   function automatic int nl_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   function automatic int to_of(input int k);
      case (k)
         0:       return 8;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int obs_layer(input int k);
      case (k)
         0:       return int'(l4);
         1:       return int'(l1);
         default: return int'(l5);
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_phase[k] = 0;
         m_lay[k]   = 0;
         m_wait[k]  = 0;
         m_terr[k]  = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         if (ab[k]) begin
            m_phase[k] = 0;
            m_lay[k]   = 0;
            m_wait[k]  = 0;
         end else begin
            case (m_phase[k])
               0: if (st[k]) begin
                     m_phase[k] = 1;
                     m_lay[k]   = 0;
                     m_terr[k]  = 0;
                  end
               1: begin
                     m_wait[k]  = 0;
                     m_phase[k] = 2;
                  end
               2: if (dn[k])
                     m_phase[k] = 3;
                  else if (to_of(k) != 0 && m_wait[k] == to_of(k) - 1) begin
                     m_terr[k]  = 1;
                     m_lay[k]   = 0;
                     m_phase[k] = 0;
                  end else
                     m_wait[k]++;
               default: if (m_lay[k] == nl_of(k) - 1) begin
                     m_lay[k]   = 0;
                     m_phase[k] = 0;
                  end else begin
                     m_lay[k]++;
                     m_phase[k] = 1;
                  end
            endcase
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ram_start[%0d]", k), int'(rs[k]), int'(m_phase[k] == 1));
         chk($sformatf("busy[%0d]", k), int'(bz[k]), int'(m_phase[k] != 0));
         chk($sformatf("net_done[%0d]", k), int'(nd[k]),
             int'(m_phase[k] == 3 && m_lay[k] == nl_of(k) - 1));
         chk($sformatf("layer[%0d]", k), obs_layer(k), m_lay[k]);
         chk($sformatf("layer_sel[%0d]", k), int'(ls[k]), int'(m_lay[k] != nl_of(k) - 1));
         chk($sformatf("timeout_err[%0d]", k), int'(te[k]), m_terr[k]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_step();
      #1;
      check_all();
   endtask

   task automatic drive_random();
      for (int k = 0; k < 3; k++) begin
         st[k] = ($urandom_range(3) == 0);
         dn[k] = ($urandom_range(2) == 0);
         ab[k] = ($urandom_range(59) == 0);
      end
   endtask

   task automatic drive_idle();
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0;
         dn[k] = 1'b0;
         ab[k] = 1'b0;
      end
   endtask

   initial begin
      bit reached;
      reset = 1'b1;
      drive_idle();
      model_reset();
      #1;
      check_all();
      repeat (2) cycle();
      reset = 1'b0;

      repeat (3000) begin
         drive_random();
         cycle();
      end

      // Drive build 0 into WAIT, then hit reset between clock edges.
      drive_idle();
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         st[0] = 1'b1;
         cycle();
         reached = (m_phase[0] == 2);
      end
      chk("reach_wait", int'(reached), 1);
      st[0] = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      cycle();
      reset = 1'b0;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Parametrised layer sequencer for the neural network datapath. Steps through NUM_LAYERS layers. For each layer it launches the RAM/MAC controller with a one-cycle start pulse and waits for that controller's done. Sits between the top-level host handshake and the RAM controller, and drives the layer index and output-layer select. Adds the following: any layer count, abort, a per-layer watchdog timeout, busy status, and an end-of-network pulse.

Parameters:
NUM_LAYERS, 4, number of layers per inference (>=1)
LAYER_W, $clog2(NUM_LAYERS) min 1, width of layer index
TIMEOUT_CYCLES, 1024, max WAIT cycles per layer before error; 0 disables watchdog
TO_W, $clog2(TIMEOUT_CYCLES+1) min 1, watchdog counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin inference; sampled only in IDLE
done  in  1  RAM controller finished current layer; sampled only in WAIT
abort  in  1  cancel sequence; sampled in every state
layer  out  LAYER_W  current layer index
layer_sel  out  1  1 = hidden layer, 0 = final (output) layer
ram_start  out  1  one-cycle launch pulse to RAM controller
busy  out  1  high whenever state != IDLE
net_done  out  1  one-cycle pulse: final layer completed
timeout_err  out  1  sticky; set on watchdog expiry, cleared on accepted start

Behaviour:
- Reset (async): state=IDLE, layer=0, timer=0, timeout_err=0. Consequently ram_start=0, busy=0, net_done=0, layer_sel=(NUM_LAYERS>1).
- States: IDLE, LAUNCH, WAIT, ADVANCE. Registered state; outputs are Moore decodes of the state and layer registers.
- IDLE: start=1 -> LAUNCH; layer<=0; timeout_err<=0. Otherwise hold.
- LAUNCH: ram_start=1 for exactly this cycle; timer<=0; -> WAIT unconditionally.
- WAIT: done=1 -> ADVANCE. Else timer++. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with done=0 -> timeout_err<=1, layer<=0, -> IDLE.
- WAIT, done and expiry in the same cycle: done wins.
- ADVANCE:
  - If layer==NUM_LAYERS-1: net_done=1 this cycle, layer<=0, -> IDLE.
  - Else: layer<=layer+1, -> LAUNCH.
- Latency: start sampled at cycle n -> ram_start high at n+1. done sampled at cycle m -> next ram_start at m+2, or net_done at m+1.
- layer_sel = 0 iff layer==NUM_LAYERS-1; combinational from layer.
- busy = (state != IDLE).
- Priority: abort > done/timeout > start. abort=1 in any state -> IDLE next cycle, layer<=0, timer<=0. No ram_start, no net_done, timeout_err unchanged.
- Ignored inputs: start while busy; done outside WAIT.
- layer never exceeds NUM_LAYERS-1 and never wraps mid-sequence.
- NUM_LAYERS=1: single LAUNCH/WAIT/ADVANCE pass; layer_sel held 0.
- Reset asserted mid-sequence: immediate return to reset values; no pulses emitted.
- Timer saturates; it never wraps.

Decomposition:
- Package layer_seq_pkg: state enum (IDLE=0, LAUNCH=1, WAIT=2, ADVANCE=3), 2-bit state typedef, clog2-min-1 helper function.
- One sub-module, layer_watchdog: loadable saturating counter. Inputs clear, enable. Output expired. Parameters TIMEOUT_CYCLES and TO_W; tied off when TIMEOUT_CYCLES=0.

Test Plan:
1. Nominal run (NUM_LAYERS=4): start pulse; done returned 3 cycles after each ram_start -> exactly 4 ram_start pulses with layer=0,1,2,3 and layer_sel=1,1,1,0; one net_done; busy low the cycle after net_done; layer=0.
2. Watchdog (TIMEOUT_CYCLES=8): start, never assert done -> timeout_err rises 8 cycles after the WAIT entry for layer 0; state IDLE; no net_done; next start clears timeout_err.
3. Abort during layer 2 WAIT -> next cycle busy=0, layer=0; no further ram_start; no net_done; a later start runs all 4 layers normally.
4. Spurious inputs: done pulsed in IDLE and LAUNCH, start pulsed during WAIT -> no state change, no extra ram_start.
5. Simultaneous events: done and timer expiry in the same cycle -> ADVANCE, no error. abort and done in the same cycle -> IDLE, no net_done.
6. NUM_LAYERS=1 and NUM_LAYERS=5 builds: layer_sel always 0 (N=1). Five launches with layer 0..4 (N=5). Async reset asserted mid-WAIT -> all outputs reach reset values without waiting for a clock edge.
